// File: rtl/systolic_pkg.sv
// systolic_pkg: shared dimensions, widths and FSM encodings for the systolic array blocks
package systolic_pkg;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int DRAIN = 4;
  localparam int AW = $clog2(N * N);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2((2 * N - 1) > DRAIN ? (2 * N - 1) : DRAIN);
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_FEED = 2'd2;
  localparam state_t S_DRAIN = 2'd3;
  localparam logic [CW-1:0] K_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN - 1);
  localparam logic [CW-1:0] N_C = CW'(N);
endpackage

// File: rtl/systolic_skew_lane.sv
// systolic_skew_lane: registers one skewed operand lane, element k-idx of its vector or zero
module systolic_skew_lane
  import systolic_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [CW-1:0] k_i,
  input  logic [CW-1:0] idx_i,
  input  logic [DW-1:0] vec_i [N],
  output logic [DW-1:0] out_o
);
  logic [CW-1:0] diff;
  logic [DW-1:0] out_d, out_q;
  // pick the element this lane owes at step k, zero outside its skew window
  always_comb begin
    diff = k_i - idx_i;
    out_d = (en_i && k_i >= idx_i && diff < N_C) ? vec_i[diff[LW-1:0]] : '0;
  end
  // lane output register
  always_ff @(posedge clk_i) begin
    out_q <= rst_i ? '0 : out_d;
  end
  assign out_o = out_q;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A/B and streams them skewed into the systolic array
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic          wr_sel_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          clr_o,
  output logic [DW-1:0] left_o_0,
  output logic [DW-1:0] left_o_4,
  output logic [DW-1:0] left_o_8,
  output logic [DW-1:0] left_o_12,
  output logic [DW-1:0] up_o_0,
  output logic [DW-1:0] up_o_1,
  output logic [DW-1:0] up_o_2,
  output logic [DW-1:0] up_o_3,
  output logic          feed_valid_o,
  output logic          done_o
);
  state_t state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic done_q, done_d;
  logic wr_en, feed_next;
  logic [DW-1:0] a_q [N*N];
  logic [DW-1:0] a_d [N*N];
  logic [DW-1:0] b_q [N*N];
  logic [DW-1:0] b_d [N*N];
  logic [DW-1:0] a_row [N][N];
  logic [DW-1:0] b_col [N][N];
  logic [DW-1:0] left [N];
  logic [DW-1:0] up [N];
  // sequence IDLE -> CLEAR -> FEED (2N-1 steps) -> DRAIN -> IDLE, done on return to IDLE
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    done_d = 1'b0;
    if (state_q == S_IDLE && start_i) begin
      state_d = S_CLEAR;
      k_d = '0;
    end else if (state_q == S_CLEAR) begin
      state_d = S_FEED;
      k_d = '0;
    end else if (state_q == S_FEED) begin
      state_d = (k_q == K_LAST) ? S_DRAIN : S_FEED;
      k_d = (k_q == K_LAST) ? '0 : k_q + CW'(1);
    end else if (state_q == S_DRAIN) begin
      state_d = (k_q == D_LAST) ? S_IDLE : S_DRAIN;
      k_d = (k_q == D_LAST) ? '0 : k_q + CW'(1);
      done_d = (k_q == D_LAST);
    end
    feed_next = (state_d == S_FEED);
  end
  // element writes land only while idle; out-of-range addresses are swallowed
  always_comb begin
    wr_en = wr_valid_i && state_q == S_IDLE && int'(wr_addr_i) < N * N;
    a_d = a_q;
    b_d = b_q;
    if (wr_en && !wr_sel_i) a_d[wr_addr_i] = wr_data_i;
    if (wr_en && wr_sel_i) b_d[wr_addr_i] = wr_data_i;
  end
  // FSM, step counter, done pulse and operand storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q <= '0;
      done_q <= 1'b0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      done_q <= done_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  // lanes see the next step so their registered output lines up with the FEED cycle
  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar j = 0; j < N; j++) begin : g_map
      assign a_row[i][j] = a_q[i*N+j];
      assign b_col[i][j] = b_q[j*N+i];
    end
    systolic_skew_lane u_left (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (feed_next),
      .k_i   (k_d),
      .idx_i (CW'(i)),
      .vec_i (a_row[i]),
      .out_o (left[i])
    );
    systolic_skew_lane u_up (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (feed_next),
      .k_i   (k_d),
      .idx_i (CW'(i)),
      .vec_i (b_col[i]),
      .out_o (up[i])
    );
  end
  assign wr_ready_o = (state_q == S_IDLE);
  assign busy_o = (state_q != S_IDLE);
  assign clr_o = (state_q == S_CLEAR);
  assign feed_valid_o = (state_q == S_FEED);
  assign done_o = done_q;
  assign left_o_0 = left[0];
  assign left_o_4 = left[1];
  assign left_o_8 = left[2];
  assign left_o_12 = left[3];
  assign up_o_0 = up[0];
  assign up_o_1 = up[1];
  assign up_o_2 = up[2];
  assign up_o_3 = up[3];
endmodule
